// File: rtl/nrisc_pkg.sv
// Shared constants and state encoding for the nrisc instruction-memory loader
// and the instruction memory it programs.
package nrisc_pkg;

  localparam int         IDATA_LENGTH = 1024;
  localparam int         IDATA_AW     = $clog2(IDATA_LENGTH);
  localparam int         IDATA_DW     = 16;
  localparam logic [7:0] SYNC_BYTE    = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/nrisc_xor_accum.sv
// 8-bit clear/enable XOR accumulator for the loader frame checksum.
// Only present when NRISC_IDATA_LOADER_CHECKSUM_EN is defined.
`ifdef NRISC_IDATA_LOADER_CHECKSUM_EN
module nrisc_xor_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] acc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     acc <= 8'h00;
    else if (clr) acc <= 8'h00;
    else if (en)  acc <= acc ^ d;
  end

endmodule
`endif

// File: rtl/nrisc_idata_loader.sv
// Byte-stream boot loader: parses SYNC/LEN/data frames and writes 16-bit words
// into instruction memory. Define NRISC_IDATA_LOADER_CHECKSUM_EN for a trailing XOR checksum.
module nrisc_idata_loader
  import nrisc_pkg::*;
#(
  parameter int         LENGTH = IDATA_LENGTH,
  parameter int         AW     = IDATA_AW,
  parameter logic [7:0] SYNC   = SYNC_BYTE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic                IDATA_PROG_write,
  output logic [AW-1:0]       IDATA_PROG_addr,
  output logic [IDATA_DW-1:0] IDATA_PROG_data,
  output logic                core_hold,
  output logic                load_done,
  output logic                load_err
);

  localparam logic [16:0] LEN_MAX = 17'(LENGTH);

  state_t      state_q, state_d;
  logic [7:0]  len_lo_q;
  logic [15:0] len_q;
  logic [AW:0] cnt_q;
  logic [7:0]  lo_q;

  logic        xfer;
  logic [15:0] len_in;
  logic        len_bad;
  logic [16:0] cnt_inc;
  logic        sync_hit;

  assign xfer     = byte_valid & byte_ready;
  assign len_in   = {byte_in, len_lo_q};
  assign len_bad  = (len_in == 16'd0) || ({1'b0, len_in} > LEN_MAX);
  assign cnt_inc  = 17'(cnt_q) + 17'd1;
  assign sync_hit = (state_q == ST_IDLE) && xfer && (byte_in == SYNC);

`ifdef NRISC_IDATA_LOADER_CHECKSUM_EN
  logic [7:0] chk_acc;
  logic       data_byte;

  assign data_byte = xfer && ((state_q == ST_DATA_LO) || (state_q == ST_DATA_HI));

  nrisc_xor_accum u_xor_accum (
    .clk (clk),
    .rst (rst),
    .clr (sync_hit),
    .en  (data_byte),
    .d   (byte_in),
    .acc (chk_acc)
  );
`endif

  assign byte_ready       = !(state_q inside {ST_WRITE, ST_DONE, ST_ERR});
  assign IDATA_PROG_write = (state_q == ST_WRITE);
  assign load_done        = (state_q == ST_DONE);
  assign core_hold        = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA_LO,
                                            ST_DATA_HI, ST_WRITE, ST_CHK};

  // NOTE: every signal driven here gets a default before the case, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (sync_hit) state_d = ST_LEN_LO;
      ST_LEN_LO:  if (xfer) state_d = ST_LEN_HI;
      ST_LEN_HI:  if (xfer) state_d = len_bad ? ST_ERR : ST_DATA_LO;
      ST_DATA_LO: if (xfer) state_d = ST_DATA_HI;
      ST_DATA_HI: if (xfer) state_d = ST_WRITE;
      ST_WRITE: begin
        if (cnt_inc < {1'b0, len_q}) state_d = ST_DATA_LO;
`ifdef NRISC_IDATA_LOADER_CHECKSUM_EN
        else                         state_d = ST_CHK;
`else
        else                         state_d = ST_DONE;
`endif
      end
`ifdef NRISC_IDATA_LOADER_CHECKSUM_EN
      ST_CHK:     if (xfer) state_d = (byte_in == chk_acc) ? ST_DONE : ST_ERR;
`else
      ST_CHK:     state_d = ST_IDLE;
`endif
      ST_DONE:    state_d = ST_IDLE;
      ST_ERR:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      len_lo_q        <= 8'h00;
      len_q           <= 16'h0000;
      cnt_q           <= '0;
      lo_q            <= 8'h00;
      IDATA_PROG_addr <= '0;
      IDATA_PROG_data <= '0;
      load_err        <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (sync_hit) begin
          load_err <= 1'b0;
          cnt_q    <= '0;
        end
        ST_LEN_LO:  if (xfer) len_lo_q <= byte_in;
        ST_LEN_HI:  if (xfer) begin
          len_q <= len_in;
          cnt_q <= '0;
        end
        ST_DATA_LO: if (xfer) lo_q <= byte_in;
        // Address/data are staged here so they are stable for the whole WRITE
        // cycle and then simply hold afterwards.
        ST_DATA_HI: if (xfer) begin
          IDATA_PROG_addr <= cnt_q[AW-1:0];
          IDATA_PROG_data <= {byte_in, lo_q};
        end
        ST_WRITE:   cnt_q <= cnt_q + 1'b1;
        default: ;
      endcase
      if (state_d == ST_ERR) load_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nrisc_idata_loader.sv
// Self-checking bench for nrisc_idata_loader: table-driven frames, a write
// scoreboard, and hand sequences for reset, error recovery and full-depth load.
module tb_nrisc_idata_loader;
  import nrisc_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic [7:0]          byte_in;
  logic                byte_valid;
  logic                byte_ready;
  logic                IDATA_PROG_write;
  logic [IDATA_AW-1:0] IDATA_PROG_addr;
  logic [15:0]         IDATA_PROG_data;
  logic                core_hold;
  logic                load_done;
  logic                load_err;

  always #5 clk = ~clk;

  nrisc_idata_loader dut (
    .clk              (clk),
    .rst              (rst),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .IDATA_PROG_write (IDATA_PROG_write),
    .IDATA_PROG_addr  (IDATA_PROG_addr),
    .IDATA_PROG_data  (IDATA_PROG_data),
    .core_hold        (core_hold),
    .load_done        (load_done),
    .load_err         (load_err)
  );

  typedef struct packed {
    logic [IDATA_AW-1:0] addr;
    logic [15:0]         data;
  } wr_t;

  typedef struct packed {
    logic [0:7][7:0]  b;
    logic [3:0]       nb;
    logic [2:0]       gap;
    logic             add_chk;
    logic             exp_done;
    logic             exp_err;
    logic [1:0]       nwr;
    logic [0:1][15:0] wd;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[5];
  int   passed = 0;
  int   total  = 0;
  int   done_cnt = 0;
  int   last_addr = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Write scoreboard and done-pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && IDATA_PROG_write) begin
      check("ready_low_in_write", 32'(byte_ready), 32'd0);
      if (sb.size() == 0) check("unexpected_write", 32'(IDATA_PROG_addr), 32'hFFFF_FFFF);
      else begin
        wr_t e;
        e = sb.pop_front();
        check("write_addr", 32'(IDATA_PROG_addr), 32'(e.addr));
        check("write_data", 32'(IDATA_PROG_data), 32'(e.data));
      end
      last_addr = int'(IDATA_PROG_addr);
    end
    if (rst && load_done) begin
      done_cnt++;
      check("hold_low_at_done", 32'(core_hold), 32'd0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Entered and left at a falling edge; byte_valid stays high on return.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    bit   ok = 0;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rdy = byte_ready;
      @(negedge clk);
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic settle();
    byte_valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end_checks(input string tag, input int done0, input logic exp_done,
                                  input logic exp_err);
    check({tag, "_done_pulses"}, 32'(done_cnt - done0), 32'(exp_done));
    check({tag, "_load_err"}, 32'(load_err), 32'(exp_err));
    check({tag, "_core_hold"}, 32'(core_hold), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         done0 = done_cnt;
    logic [7:0] chk = 8'h00;
    for (int i = 0; i < int'(v.nwr); i++) begin
      sb.push_back('{addr: IDATA_AW'(i), data: v.wd[i]});
      chk ^= v.wd[i][7:0] ^ v.wd[i][15:8];
    end
    for (int i = 0; i < int'(v.nb); i++)
      send_byte(v.b[i], int'($urandom_range(0, int'(v.gap))));
`ifdef NRISC_IDATA_LOADER_CHECKSUM_EN
    if (v.add_chk) send_byte(chk, 0);
`endif
    settle();
    frame_end_checks($sformatf("vec%0d", idx), done0, v.exp_done, v.exp_err);
  endtask

  initial begin
    int         done0;
    logic [7:0] chk;
    logic [15:0] w;

    vecs[0] = '{b: {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00}, nb: 4'd7, gap: 3'd0,
                add_chk: 1'b1, exp_done: 1'b1, exp_err: 1'b0, nwr: 2'd2, wd: {16'h1234, 16'hABCD}};
    vecs[1] = vecs[0];
    vecs[1].gap = 3'd5;
    vecs[2] = '{b: {8'hA5, 8'h00, 8'h00, 40'h0}, nb: 4'd3, gap: 3'd2,
                add_chk: 1'b0, exp_done: 1'b0, exp_err: 1'b1, nwr: 2'd0, wd: 32'h0};
    vecs[3] = '{b: {8'hA5, 8'h01, 8'h04, 40'h0}, nb: 4'd3, gap: 3'd1,
                add_chk: 1'b0, exp_done: 1'b0, exp_err: 1'b1, nwr: 2'd0, wd: 32'h0};
    vecs[4] = '{b: {8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5}, nb: 4'd8, gap: 3'd1,
                add_chk: 1'b1, exp_done: 1'b1, exp_err: 1'b0, nwr: 2'd1, wd: {16'hA5A5, 16'h0}};

    rst = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    #12;
    check("rst_byte_ready", 32'(byte_ready), 32'd1);
    check("rst_write", 32'(IDATA_PROG_write), 32'd0);
    check("rst_addr", 32'(IDATA_PROG_addr), 32'd0);
    check("rst_data", 32'(IDATA_PROG_data), 32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Error flag from an over-long frame is cleared by the next SYNC.
    run_vec(vecs[3], 3);
    done0 = done_cnt;
    send_byte(8'hA5, 0);
    check("err_cleared_by_sync", 32'(load_err), 32'd0);
    check("hold_after_sync", 32'(core_hold), 32'd1);
    sb.push_back('{addr: '0, data: 16'h2211});
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h11, 1); send_byte(8'h22, 0);
`ifdef NRISC_IDATA_LOADER_CHECKSUM_EN
    send_byte(8'h33, 0);
`endif
    settle();
    frame_end_checks("recover", done0, 1'b1, 1'b0);

    // Asynchronous reset partway through the data field.
    sb.push_back('{addr: '0, data: 16'h2211});
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    byte_valid = 1'b0;
    check("pre_rst_hold", 32'(core_hold), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_core_hold", 32'(core_hold), 32'd0);
    check("arst_byte_ready", 32'(byte_ready), 32'd1);
    check("arst_addr", 32'(IDATA_PROG_addr), 32'd0);
    check("arst_data", 32'(IDATA_PROG_data), 32'd0);
    check("arst_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_vec(vecs[0], 0);

    // Garbage, then a full-depth frame: addresses 0..LENGTH-1, no wrap.
    done0 = done_cnt;
    chk = 8'h00;
    send_byte(8'h00, 0); send_byte(8'hFF, 2); send_byte(8'h12, 0);
    check("garbage_no_hold", 32'(core_hold), 32'd0);
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
    for (int i = 0; i < IDATA_LENGTH; i++) begin
      w = 16'(i) ^ 16'hC35A;
      sb.push_back('{addr: IDATA_AW'(i), data: w});
      chk ^= w[7:0] ^ w[15:8];
      send_byte(w[7:0], 0);
      send_byte(w[15:8], 0);
    end
`ifdef NRISC_IDATA_LOADER_CHECKSUM_EN
    send_byte(chk, 0);
`endif
    settle();
    frame_end_checks("full", done0, 1'b1, 1'b0);
    check("full_last_addr", 32'(last_addr), 32'(IDATA_LENGTH - 1));

`ifdef NRISC_IDATA_LOADER_CHECKSUM_EN
    done0 = done_cnt;
    sb.push_back('{addr: '0, data: 16'h1234});
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h34, 0); send_byte(8'h12, 0); send_byte(8'h26, 0);
    settle();
    frame_end_checks("chk_good", done0, 1'b1, 1'b0);

    done0 = done_cnt;
    sb.push_back('{addr: '0, data: 16'h1234});
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h34, 0); send_byte(8'h12, 0); send_byte(8'h27, 0);
    settle();
    frame_end_checks("chk_bad", done0, 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
